mrnaiso_sequencer: RTL
======================

Name: mrnaiso_sequencer

Overview:
- Autonomous phase sequencer for the mRNA-isolation valve network.
- Drives every pneumatic control line of the chip: cell load, lysis buffer, three-valve peristaltic ring pump, bead load, separation, sieve, waste and collect valves.
- Runs one full isolation protocol per start pulse: load, lyse, mix, bead capture, wash, elute.
- Sits between the host/test controller and the pneumatic driver board; all outputs are registered so driver solenoids see glitch-free levels.

Parameters:
- CNT_W, 16, width of the phase timer and round counter.
- LOAD_CYCLES, 1000, cycles cell inlet/outlet stay open (≥1).
- LYSIS_CYCLES, 1000, cycles lysis inlet/outlet stay open (≥1).
- PUMP_STEP, 50, cycles per peristaltic pump step (≥1).
- MIX_ROUNDS, 20, full 6-step pump rounds in MIX (≥1).
- BEAD_CYCLES, 500, cycles bead valves stay open (≥1).
- WASH_CYCLES, 2000, cycles of push flow routed to waste (≥1).
- ELUTE_CYCLES, 1000, cycles of push flow routed to collect (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin protocol; sampled only in IDLE
- abort  input  1  stop protocol, close all valves
- cells_in_ctrl, cells_out_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl, pump1, pump2, pump3, sep_ctrl, beads_ctrl, sieve_ctrl, waste_ctrl, collect_ctrl  output  1 each  valve controls; 1 = pressurised = valve closed
- phase  output  3  current phase code
- busy  output  1  high in phases 1..6
- done  output  1  one-cycle pulse on completion
- aborted  output  1  one-cycle pulse after an abort

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all 13 valve controls = 1 (all valves closed);
  - phase = 0, busy = 0, done = 0, aborted = 0;
  - timer and round counter = 0.
- Phase codes: IDLE=0, LOAD=1, LYSIS=2, MIX=3, BEADS=4, WASH=5, ELUTE=6, DONE=7.
- IDLE:
  - all valves closed.
  - start=1 at edge t → phase=LOAD, with LOAD valve outputs valid from t+1.
- Phase length: each timed phase lasts exactly its parameter in cycles. The timer loads at phase entry and advances on its last cycle.
- Open valves per phase (ctrl=0); every valve not listed = 1:
  - LOAD: cells_in_ctrl, cells_out_ctrl.
  - LYSIS: lysis_in_ctrl, lysis_out_ctrl.
  - MIX: pump1..3 only, stepping every PUMP_STEP cycles. Step index starts at 0 on the first MIX cycle. (pump1,pump2,pump3) pattern:
    - step 0: 101
    - step 1: 100
    - step 2: 110
    - step 3: 010
    - step 4: 011
    - step 5: 001
    - After step 5, wrap to 0 and increment the round counter.
    - MIX ends after MIX_ROUNDS rounds, i.e. 6*PUMP_STEP*MIX_ROUNDS cycles. Pumps return to 111 on exit.
  - BEADS: beads_ctrl.
  - WASH: push_ctrl, pump1, sep_ctrl, sieve_ctrl, waste_ctrl.
  - ELUTE: push_ctrl, pump1, sep_ctrl, sieve_ctrl, collect_ctrl.
- DONE:
  - lasts 1 cycle, all valves closed, done=1;
  - then IDLE.
- start while busy or in DONE is ignored; there is no queuing.
- abort:
  - abort=1 in any busy phase → next cycle phase=IDLE, all valves=1, aborted=1 for one cycle.
  - In IDLE, abort has no effect and does not pulse aborted.
  - abort and start in the same IDLE cycle: abort wins, stay IDLE, aborted=0.
- rst mid-protocol: identical to the reset values at the next edge; no done or aborted pulse.
- Safety invariants, all cycles:
  - waste_ctrl and collect_ctrl are never both 0;
  - cells_in_ctrl=0 never coincides with lysis_in_ctrl=0;
  - at least one of pump1..3 = 1.
- Arithmetic: the timer counts down from param-1 to 0. Parameters must fit in CNT_W; exceeding it is an elaboration error.

Test Plan:
- Full run with LOAD=4, LYSIS=3, PUMP_STEP=2, MIX_ROUNDS=2, BEAD=3, WASH=5, ELUTE=4; start pulse at cycle 0 →
  - phase 1 for cycles 1-4, 2 for 5-7, 3 for 8-31, 4 for 32-34, 5 for 35-39, 6 for 40-43;
  - done=1 at cycle 44, IDLE at 45.
- MIX pattern check with the same parameters → pump1..3 read 101,101,100,100,110,110,010,010,011,011,001,001, repeated twice, then 111 at cycle 32.
- Abort at cycle 20 (in MIX) → cycle 21: phase=0, all 13 ctrls=1, aborted=1; cycle 22: aborted=0.
- Second start pulse at cycle 10 of a run → ignored; completion timing is unchanged (done at 44).
- rst asserted at cycle 37 (WASH) → cycle 38: all ctrls=1, phase=0, busy=0, no done pulse. A new start then reruns the full sequence.
- Assertion monitor over every scenario → waste/collect exclusivity, cells/lysis exclusivity and pump non-all-open are never violated.

Source files
------------

// File: rtl/mrnaiso_sequencer.sv
// Phase sequencer for the mRNA-isolation valve network: load, lyse, mix, bead capture, wash, elute.
// All valve controls, phase, busy and the done/aborted pulses are registered; 1 on a control = valve closed.
module mrnaiso_sequencer #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned LOAD_CYCLES  = 1000,
    parameter int unsigned LYSIS_CYCLES = 1000,
    parameter int unsigned PUMP_STEP    = 50,
    parameter int unsigned MIX_ROUNDS   = 20,
    parameter int unsigned BEAD_CYCLES  = 500,
    parameter int unsigned WASH_CYCLES  = 2000,
    parameter int unsigned ELUTE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       cells_in_ctrl,
    output logic       cells_out_ctrl,
    output logic       lysis_in_ctrl,
    output logic       lysis_out_ctrl,
    output logic       push_ctrl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       sep_ctrl,
    output logic       beads_ctrl,
    output logic       sieve_ctrl,
    output logic       waste_ctrl,
    output logic       collect_ctrl,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LYSIS = 3'd2,
        S_MIX   = 3'd3,
        S_BEADS = 3'd4,
        S_WASH  = 3'd5,
        S_ELUTE = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    localparam int unsigned VW      = 13;
    localparam int unsigned V_CIN   = 12;
    localparam int unsigned V_COUT  = 11;
    localparam int unsigned V_LIN   = 10;
    localparam int unsigned V_LOUT  = 9;
    localparam int unsigned V_PUSH  = 8;
    localparam int unsigned V_P1    = 7;
    localparam int unsigned V_P3    = 5;
    localparam int unsigned V_SEP   = 4;
    localparam int unsigned V_BEADS = 3;
    localparam int unsigned V_SIEVE = 2;
    localparam int unsigned V_WASTE = 1;
    localparam int unsigned V_COLL  = 0;

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Every timed parameter must be non-zero and representable in the counters.
    if (LOAD_CYCLES == 0 || 64'(LOAD_CYCLES) > CNT_MAX) begin : g_err_load
        $error("LOAD_CYCLES out of range for CNT_W");
    end
    if (LYSIS_CYCLES == 0 || 64'(LYSIS_CYCLES) > CNT_MAX) begin : g_err_lysis
        $error("LYSIS_CYCLES out of range for CNT_W");
    end
    if (PUMP_STEP == 0 || 64'(PUMP_STEP) > CNT_MAX) begin : g_err_step
        $error("PUMP_STEP out of range for CNT_W");
    end
    if (MIX_ROUNDS == 0 || 64'(MIX_ROUNDS) > CNT_MAX) begin : g_err_rounds
        $error("MIX_ROUNDS out of range for CNT_W");
    end
    if (BEAD_CYCLES == 0 || 64'(BEAD_CYCLES) > CNT_MAX) begin : g_err_bead
        $error("BEAD_CYCLES out of range for CNT_W");
    end
    if (WASH_CYCLES == 0 || 64'(WASH_CYCLES) > CNT_MAX) begin : g_err_wash
        $error("WASH_CYCLES out of range for CNT_W");
    end
    if (ELUTE_CYCLES == 0 || 64'(ELUTE_CYCLES) > CNT_MAX) begin : g_err_elute
        $error("ELUTE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LOAD_RLD  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LYSIS_RLD = CNT_W'(LYSIS_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_RLD  = CNT_W'(PUMP_STEP - 1);
    localparam logic [CNT_W-1:0] ROUND_END = CNT_W'(MIX_ROUNDS - 1);
    localparam logic [CNT_W-1:0] BEAD_RLD  = CNT_W'(BEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WASH_RLD  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ELUTE_RLD = CNT_W'(ELUTE_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] rounds;
    logic [2:0]       step;
    logic [VW-1:0]    valves;

    // Peristaltic pattern (pump1,pump2,pump3); never all three open at once.
    function automatic logic [2:0] pump_pattern(input logic [2:0] s);
        logic [2:0] p;
        case (s)
            3'd0:    p = 3'b101;
            3'd1:    p = 3'b100;
            3'd2:    p = 3'b110;
            3'd3:    p = 3'b010;
            3'd4:    p = 3'b011;
            3'd5:    p = 3'b001;
            default: p = 3'b111;
        endcase
        return p;
    endfunction

    // Valve image for the phase being entered; clearing a bit opens that valve.
    function automatic logic [VW-1:0] valve_map(input state_e s, input logic [2:0] st);
        logic [VW-1:0] v;
        v = '1;
        case (s)
            S_LOAD: begin
                v[V_CIN]  = 1'b0;
                v[V_COUT] = 1'b0;
            end
            S_LYSIS: begin
                v[V_LIN]  = 1'b0;
                v[V_LOUT] = 1'b0;
            end
            S_MIX:   v[V_P1:V_P3] = pump_pattern(st);
            S_BEADS: v[V_BEADS] = 1'b0;
            S_WASH, S_ELUTE: begin
                v[V_PUSH]  = 1'b0;
                v[V_P1]    = 1'b0;
                v[V_SEP]   = 1'b0;
                v[V_SIEVE] = 1'b0;
                if (s == S_WASH) v[V_WASTE] = 1'b0;
                else             v[V_COLL]  = 1'b0;
            end
            default: ;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            rounds  <= '0;
            step    <= '0;
            valves  <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state  <= S_LOAD;
                        timer  <= LOAD_RLD;
                        busy   <= 1'b1;
                        valves <= valve_map(S_LOAD, 3'd0);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        timer   <= '0;
                        rounds  <= '0;
                        step    <= '0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        valves  <= '1;
                    end else if (timer != '0) begin
                        timer <= timer - CNT_W'(1);
                    end else begin
                        // Last cycle of the current phase or pump step.
                        case (state)
                            S_LOAD: begin
                                state  <= S_LYSIS;
                                timer  <= LYSIS_RLD;
                                valves <= valve_map(S_LYSIS, 3'd0);
                            end
                            S_LYSIS: begin
                                state  <= S_MIX;
                                timer  <= STEP_RLD;
                                step   <= 3'd0;
                                rounds <= '0;
                                valves <= valve_map(S_MIX, 3'd0);
                            end
                            S_MIX: begin
                                if (step == 3'd5 && rounds == ROUND_END) begin
                                    state  <= S_BEADS;
                                    timer  <= BEAD_RLD;
                                    step   <= 3'd0;
                                    rounds <= '0;
                                    valves <= valve_map(S_BEADS, 3'd0);
                                end else if (step == 3'd5) begin
                                    timer  <= STEP_RLD;
                                    step   <= 3'd0;
                                    rounds <= rounds + CNT_W'(1);
                                    valves <= valve_map(S_MIX, 3'd0);
                                end else begin
                                    timer  <= STEP_RLD;
                                    step   <= step + 3'd1;
                                    valves <= valve_map(S_MIX, step + 3'd1);
                                end
                            end
                            S_BEADS: begin
                                state  <= S_WASH;
                                timer  <= WASH_RLD;
                                valves <= valve_map(S_WASH, 3'd0);
                            end
                            S_WASH: begin
                                state  <= S_ELUTE;
                                timer  <= ELUTE_RLD;
                                valves <= valve_map(S_ELUTE, 3'd0);
                            end
                            default: begin
                                state  <= S_DONE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                valves <= '1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign phase          = state;
    assign cells_in_ctrl  = valves[V_CIN];
    assign cells_out_ctrl = valves[V_COUT];
    assign lysis_in_ctrl  = valves[V_LIN];
    assign lysis_out_ctrl = valves[V_LOUT];
    assign push_ctrl      = valves[V_PUSH];
    assign pump1          = valves[V_P1];
    assign pump2          = valves[V_P1-1];
    assign pump3          = valves[V_P3];
    assign sep_ctrl       = valves[V_SEP];
    assign beads_ctrl     = valves[V_BEADS];
    assign sieve_ctrl     = valves[V_SIEVE];
    assign waste_ctrl     = valves[V_WASTE];
    assign collect_ctrl   = valves[V_COLL];

endmodule
